// File: rtl/isp_awb_ctrl.sv
// ============================================================================
// Module   : isp_awb_ctrl
// Brief    : Gray-world auto white balance. Per-frame RGB sums are turned into
//            Q8.31 R/B gains by a sequential restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isp_awb_ctrl #(
    parameter int          ACC_W    = 32,
    parameter logic [38:0] GAIN_MAX = 39'h2_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vsync,
    input  logic        per_img_clken,
    input  logic [23:0] per_img_data,
    input  logic        awb_en,
    output logic [38:0] gain_r,
    output logic [38:0] gain_g,
    output logic [38:0] gain_b,
    output logic        gain_valid,
    output logic        busy
);

    localparam int DIVD_W = ACC_W + 31;
    localparam int CMP_W  = (DIVD_W > 39) ? DIVD_W : 39;
    localparam int CNT_W  = $clog2(DIVD_W + 1);

    localparam logic [38:0]       C_UNITY = 39'h0_8000_0000;
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(DIVD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_DIV_R  = 3'd2,
        S_DIV_B  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_vs_d;
    logic [ACC_W-1:0]    r_sum_r, r_sum_g, r_sum_b;
    logic [ACC_W-1:0]    r_calc_r, r_calc_g, r_calc_b;
    logic [DIVD_W-1:0]   r_dq;
    logic [ACC_W-1:0]    r_rem;
    logic [ACC_W-1:0]    r_divisor;
    logic [CNT_W-1:0]    r_cnt;
    logic [DIVD_W-1:0]   r_q_r, r_q_b;
    logic [38:0]         r_gain_r, r_gain_g, r_gain_b;
    logic                r_gain_valid;
    logic                r_busy;

    logic                w_fe;
    logic [ACC_W:0]      w_rem_sh;
    logic                w_ge;
    logic [ACC_W:0]      w_rem_nx;
    logic [DIVD_W-1:0]   w_dq_nx;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [7:0]       p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, p};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [38:0] clamp_gain(input logic [DIVD_W-1:0] q);
        logic [CMP_W-1:0] qe;
        qe = CMP_W'(q);
        return (qe > CMP_W'(GAIN_MAX)) ? GAIN_MAX : qe[38:0];
    endfunction

    assign w_fe = in_vsync & ~r_vs_d;

    // One restoring-division step: quotient bits shift into the dividend LSBs.
    assign w_rem_sh = {r_rem, r_dq[DIVD_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
    assign w_dq_nx  = {r_dq[DIVD_W-2:0], w_ge};

    // Statistics run independently of the FSM; a frame end always starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d  <= 1'b0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
        end else begin
            r_vs_d <= in_vsync;
            if (w_fe) begin
                r_sum_r <= '0;
                r_sum_g <= '0;
                r_sum_b <= '0;
            end else if (per_img_clken) begin
                r_sum_r <= sat_add(r_sum_r, per_img_data[23:16]);
                r_sum_g <= sat_add(r_sum_g, per_img_data[15:8]);
                r_sum_b <= sat_add(r_sum_b, per_img_data[7:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_calc_r     <= '0;
            r_calc_g     <= '0;
            r_calc_b     <= '0;
            r_dq         <= '0;
            r_rem        <= '0;
            r_divisor    <= '0;
            r_cnt        <= '0;
            r_q_r        <= '0;
            r_q_b        <= '0;
            r_gain_r     <= C_UNITY;
            r_gain_g     <= C_UNITY;
            r_gain_b     <= C_UNITY;
            r_gain_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_gain_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fe) begin
                        if (awb_en) begin
                            r_calc_r <= r_sum_r;
                            r_calc_g <= r_sum_g;
                            r_calc_b <= r_sum_b;
                            r_busy   <= 1'b1;
                            r_state  <= S_LATCH;
                        end else begin
                            r_gain_r     <= C_UNITY;
                            r_gain_g     <= C_UNITY;
                            r_gain_b     <= C_UNITY;
                            r_gain_valid <= 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    r_dq      <= {r_calc_g, 31'b0};
                    r_divisor <= r_calc_r;
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_DIV_R;
                end
                S_DIV_R: begin
                    r_dq  <= w_dq_nx;
                    r_rem <= w_rem_nx[ACC_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        // A zero divisor still runs the full step count so latency stays fixed.
                        r_q_r     <= (r_divisor == '0) ? DIVD_W'(C_UNITY) : w_dq_nx;
                        r_dq      <= {r_calc_g, 31'b0};
                        r_divisor <= r_calc_b;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_DIV_B;
                    end
                end
                S_DIV_B: begin
                    r_dq  <= w_dq_nx;
                    r_rem <= w_rem_nx[ACC_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_q_b   <= (r_divisor == '0) ? DIVD_W'(C_UNITY) : w_dq_nx;
                        r_cnt   <= '0;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_gain_r     <= clamp_gain(r_q_r);
                    r_gain_b     <= clamp_gain(r_q_b);
                    r_gain_g     <= C_UNITY;
                    r_gain_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gain_r     = r_gain_r;
    assign gain_g     = r_gain_g;
    assign gain_b     = r_gain_b;
    assign gain_valid = r_gain_valid;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_isp_awb_ctrl.sv
// ============================================================================
// Module   : tb_isp_awb_ctrl
// Brief    : Directed bench for isp_awb_ctrl with a gain scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isp_awb_ctrl;

    localparam logic [38:0] UNITY = 39'h0_8000_0000;
    localparam logic [38:0] GMAX  = 39'h2_0000_0000;
    localparam logic [63:0] SUM_MAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vsync;
    logic        per_img_clken;
    logic [23:0] per_img_data;
    logic        awb_en;
    logic [38:0] gain_r, gain_g, gain_b;
    logic        gain_valid;
    logic        busy;

    typedef struct packed {
        logic [38:0] r;
        logic [38:0] g;
        logic [38:0] b;
    } gains_t;

    gains_t      sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_r, m_g, m_b;

    always #5 clk = ~clk;

    isp_awb_ctrl #(.ACC_W(32), .GAIN_MAX(GMAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vsync      (in_vsync),
        .per_img_clken (per_img_clken),
        .per_img_data  (per_img_data),
        .awb_en        (awb_en),
        .gain_r        (gain_r),
        .gain_g        (gain_g),
        .gain_b        (gain_b),
        .gain_valid    (gain_valid),
        .busy          (busy)
    );

    function automatic logic [38:0] exp_gain(input logic [63:0] num, input logic [63:0] den);
        logic [63:0] q;
        if (den == 64'd0) return UNITY;
        q = (num << 31) / den;
        return (q > {25'd0, GMAX}) ? GMAX : q[38:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        m_r = (m_r + r > SUM_MAX) ? SUM_MAX : m_r + r;
        m_g = (m_g + g > SUM_MAX) ? SUM_MAX : m_g + g;
        m_b = (m_b + b > SUM_MAX) ? SUM_MAX : m_b + b;
    endtask

    task automatic drive_frame(input int n, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b);
        repeat (n) begin
            per_img_clken = 1'b1;
            per_img_data  = {r, g, b};
            add_px(r, g, b);
            tick();
        end
        per_img_clken = 1'b0;
        per_img_data  = 24'd0;
    endtask

    // Returns just after edge E0, where the frame end is seen.
    task automatic frame_end();
        gains_t e;
        if (awb_en) begin
            e.r = exp_gain(m_g, m_r);
            e.g = UNITY;
            e.b = exp_gain(m_g, m_b);
            sb.push_back(e);
        end
        m_r = 0; m_g = 0; m_b = 0;
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
    endtask

    task automatic wait_gains(input string tag);
        int     k;
        int     busy_cnt;
        gains_t e;
        k        = 0;
        busy_cnt = busy ? 1 : 0;
        while (!gain_valid && k < 300) begin
            tick();
            k++;
            if (!gain_valid && busy) busy_cnt++;
        end
        check({tag, " gain_valid seen"}, gain_valid, 1);
        check({tag, " latency"}, k, 128);
        check({tag, " busy cycles"}, busy_cnt, 128);
        check({tag, " busy after update"}, busy, 0);
        if (gain_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " gain_r"}, gain_r, e.r);
            check({tag, " gain_g"}, gain_g, e.g);
            check({tag, " gain_b"}, gain_b, e.b);
        end
        tick();
        check({tag, " single pulse"}, gain_valid, 0);
    endtask

    initial begin
        int     gv_cnt;
        int     gv_k;
        gains_t e;

        rst_n = 1'b0; in_vsync = 1'b0; per_img_clken = 1'b0;
        per_img_data = 24'd0; awb_en = 1'b1;
        m_r = 0; m_g = 0; m_b = 0;
        repeat (3) tick();
        check("reset gain_r", gain_r, UNITY);
        check("reset gain_g", gain_g, UNITY);
        check("reset gain_b", gain_b, UNITY);
        check("reset gain_valid", gain_valid, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        drive_frame(1000, 8'd64, 8'd128, 8'd32);
        frame_end();
        wait_gains("frame_a");

        drive_frame(10, 8'd0, 8'd200, 8'd25);
        frame_end();
        wait_gains("zero_r_clamp_b");

        drive_frame(40, 8'd255, 8'd255, 8'd255);
        frame_end();
        wait_gains("all_255");

        drive_frame(8, 8'd10, 8'd0, 8'd10);
        frame_end();
        wait_gains("zero_g");

        // Second frame end lands at E0+50 while the divider is running.
        drive_frame(20, 8'd64, 8'd128, 8'd64);
        frame_end();
        gv_cnt = 0;
        gv_k   = 0;
        e      = '0;
        for (int k = 1; k <= 140; k++) begin
            per_img_clken = 1'b0;
            per_img_data  = 24'd0;
            if (k >= 10 && k < 20) begin
                per_img_clken = 1'b1;
                per_img_data  = {8'd255, 8'd1, 8'd255};
            end
            if (k == 50) begin
                in_vsync      = 1'b1;
                per_img_clken = 1'b1;
                per_img_data  = {8'd255, 8'd0, 8'd255};
            end
            if (k == 51) in_vsync = 1'b0;
            if (k >= 60 && k < 80) begin
                per_img_clken = 1'b1;
                per_img_data  = {8'd50, 8'd100, 8'd200};
                add_px(8'd50, 8'd100, 8'd200);
            end
            tick();
            if (gain_valid) begin
                gv_cnt++;
                gv_k = k;
                e = {gain_r, gain_g, gain_b};
            end
        end
        per_img_clken = 1'b0;
        check("mid_fe pulse count", gv_cnt, 1);
        check("mid_fe latency", gv_k, 128);
        if (sb.size() > 0) begin
            gains_t x;
            x = sb.pop_front();
            check("mid_fe gain_r", e.r, x.r);
            check("mid_fe gain_g", e.g, x.g);
            check("mid_fe gain_b", e.b, x.b);
        end
        frame_end();
        wait_gains("next_frame_after_mid_fe");

        awb_en = 1'b0;
        drive_frame(3, 8'd10, 8'd20, 8'd30);
        frame_end();
        check("awb_off gain_valid", gain_valid, 1);
        check("awb_off busy", busy, 0);
        tick();
        check("awb_off gain_r", gain_r, UNITY);
        check("awb_off gain_g", gain_g, UNITY);
        check("awb_off gain_b", gain_b, UNITY);
        check("awb_off pulse end", gain_valid, 0);
        check("awb_off busy later", busy, 0);
        awb_en = 1'b1;

        // Reset asserted while the B division is in progress.
        drive_frame(1000, 8'd64, 8'd128, 8'd32);
        frame_end();
        repeat (80) tick();
        check("pre_reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_div reset gain_r", gain_r, UNITY);
        check("mid_div reset gain_g", gain_g, UNITY);
        check("mid_div reset gain_b", gain_b, UNITY);
        check("mid_div reset busy", busy, 0);
        check("mid_div reset gain_valid", gain_valid, 0);
        sb.delete();
        m_r = 0; m_g = 0; m_b = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        gv_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (gain_valid) gv_cnt++;
        end
        check("post_reset no pulse", gv_cnt, 0);

        drive_frame(5, 8'd100, 8'd100, 8'd50);
        frame_end();
        wait_gains("post_reset_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/isp_awb_ctrl.md
ISP_AWB_CTRL -- requirements
Module: isp_awb_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 32: width of each per-channel sum accumulator.
REQ-002 SHALL have parameter GAIN_MAX, default 39'h2_0000_0000 (4.0 in Q8.31): upper clamp for computed gains.
REQ-003 SHALL have port clk, input, 1: clock, all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_vsync, input, 1: frame sync, active high; its rising edge marks frame end.
REQ-006 SHALL have port per_img_clken, input, 1: pixel valid qualifier.
REQ-007 SHALL have port per_img_data, input, 24: pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port awb_en, input, 1: 1 = compute gains, 0 = force unity gains.
REQ-009 SHALL have ports gain_r, gain_g, gain_b, output, 39 each: Q8.31 gains for the white-balance datapath.
REQ-010 SHALL have port gain_valid, output, 1: one-cycle pulse when gains change.
REQ-011 SHALL have port busy, output, 1: high while a gain computation is in progress.

Function
REQ-012 SHALL register in_vsync once (vs_d); frame-end edge fe = in_vsync & ~vs_d.
REQ-013 SHALL accumulate R, G and B into sum_r/sum_g/sum_b on every cycle with per_img_clken=1 and fe=0, in all FSM states.
REQ-014 Accumulators SHALL saturate at 2^ACC_W-1, never wrap.
REQ-015 On fe, accumulators SHALL clear to 0, and a pixel with per_img_clken=1 in that same cycle SHALL be discarded.
REQ-016 SHALL use FSM states IDLE, LATCH, DIV_R, DIV_B, UPDATE; reset state IDLE.
REQ-017 IDLE with fe and awb_en=1: SHALL snapshot sum_r/sum_g/sum_b (pre-clear values) into calc registers and go to LATCH.
REQ-018 IDLE with fe and awb_en=0: SHALL load all three gains with unity 39'h0_8000_0000, pulse gain_valid next cycle, and stay in IDLE.
REQ-019 LATCH (1 cycle): SHALL load divider with dividend sum_g<<31 (63 bits) and divisor sum_r, then go to DIV_R.
REQ-020 DIV_R and DIV_B SHALL each run a restoring divider producing one quotient bit per cycle for exactly 63 cycles.
REQ-021 On DIV_R completion: SHALL store quotient q_r, reload the divider with sum_g<<31 / sum_b, and enter DIV_B.
REQ-022 UPDATE (1 cycle): SHALL write gain_r=min(q_r,GAIN_MAX), gain_b=min(q_b,GAIN_MAX), gain_g=39'h0_8000_0000, pulse gain_valid, and return to IDLE.
REQ-023 A zero divisor (sum_r=0 or sum_b=0) SHALL yield unity for that channel, with no divider error.
REQ-024 sum_g=0 with a nonzero divisor SHALL yield gain 0 for that channel.
REQ-025 Latency: with fe sampled at edge E0, gains and gain_valid SHALL update at edge E0+128 (LATCH 1 + DIV_R 63 + DIV_B 63 + UPDATE 1).
REQ-026 busy SHALL be 1 in LATCH, DIV_R, DIV_B and UPDATE, and 0 in IDLE.
REQ-027 An fe while busy=1 SHALL clear accumulators but SHALL NOT snapshot, restart or abort the computation in progress.
REQ-028 Gains SHALL hold their value between updates; awb_en changes SHALL take effect only at an fe seen in IDLE.

Reset
REQ-029 On rst_n=0, all state SHALL clear asynchronously, including mid-division: FSM=IDLE, accumulators=0, calc/divider registers=0, gain_r/g/b=39'h0_8000_0000, gain_valid=0, busy=0.
REQ-030 After release, the first fe SHALL be treated as a normal frame end: any partial sums present are used.

Verification
REQ-031 Reset with no stimulus -> all gains 39'h0_8000_0000, gain_valid=0, busy=0.
REQ-032 Frame of 1000 pixels R=64 G=128 B=32, then fe -> at E0+128: gain_r=39'h1_0000_0000, gain_b=39'h2_0000_0000, gain_g=unity, one gain_valid pulse, busy high exactly 128 cycles.
REQ-033 Frame R=0 G=200 B=25 -> gain_r=unity (zero divisor); gain_b clamped from 8.0 to 39'h2_0000_0000. Frame R=G=B=255 -> all unity.
REQ-034 Second fe at E0+50 during computation -> result still from frame 1 at E0+128; no second gain_valid; next frame's sums exclude pixels before E0+50.
REQ-035 awb_en=0 at fe after non-unity gains -> all gains unity at E0+1, busy stays 0; rst_n asserted in DIV_B -> immediate reset values, no gain_valid.
